// File: rtl/ysyx_25040111_exu_sb_pkg.sv
// Package: ysyx_25040111_exu_sb_pkg
// Default geometry of the EXU issue scoreboard and the field widths of the
// opaque payload bundle (opt/pc/imm) that travels through it unchanged.
package ysyx_25040111_exu_sb_pkg;
   localparam int SB_AW    = 4;   // tracked register address bits (RV32E)
   localparam int SB_NRET  = 2;   // writeback/retire channels
   localparam int SB_CNTW  = 2;   // pending-write counter width
   localparam int SB_DEPTH = 2;   // input queue entries

   localparam int SB_OPT_W = 32;
   localparam int SB_PC_W  = 32;
   localparam int SB_IMM_W = 32;
   localparam int SB_PW    = SB_OPT_W + SB_PC_W + SB_IMM_W;
endpackage

// File: rtl/ysyx_25040111_sfifo.sv
// Module: ysyx_25040111_sfifo
// Generic synchronous FIFO with a flush that empties it at the next edge.
// Ports:
//   clock, reset      clock, synchronous active-high reset
//   flush             drop every entry; a push in the same cycle is dropped
//   push_valid/ready  write handshake, push_ready = not full
//   push_data         W-bit entry
//   pop_valid/ready   read handshake, pop_valid = not empty
//   pop_data          head entry (valid while pop_valid)
module ysyx_25040111_sfifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   output logic         pop_valid,
   input  logic         pop_ready,
   output logic [W-1:0] pop_data
);
   localparam int PTRW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PTRW:0] wr_ptr, rd_ptr;   // MSB is the wrap bit
   logic          full, empty, do_push, do_pop;

   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[PTRW] != rd_ptr[PTRW]) &&
                       (wr_ptr[PTRW-1:0] == rd_ptr[PTRW-1:0]);
   assign push_ready = ~full;
   assign pop_valid  = ~empty;
   assign pop_data   = mem[rd_ptr[PTRW-1:0]];
   assign do_push    = push_valid & ~full & ~flush;
   assign do_pop     = pop_ready & ~empty & ~flush;

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PTRW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PTRW+1)'(1);
      end
   end

   // NOTE: storage has no reset; only the pointers decide which entries are live.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[PTRW-1:0]] <= push_data;
   end
endmodule

// File: rtl/ysyx_25040111_exu_sb.sv
// Module: ysyx_25040111_exu_sb
// Issue scoreboard between IDU and EXU. Decoded instructions wait in a small
// FIFO; the head is released only when none of its sources has an outstanding
// long-latency write. Per-register counters track those writes and are
// decremented by NRET writeback channels.
// Ports:
//   clock, reset                    clock, synchronous active-high reset
//   in_valid/in_ready               IDU handshake (in_ready = queue not full)
//   in_payload, in_rd/rs1/rs2       instruction bundle and register fields
//   in_lock                         long-latency write: lock rd on issue
//   out_valid/out_ready             EXU handshake for the queue head
//   out_payload, out_rd             head bundle and destination
//   ret_valid, ret_rd               per-channel retire, channel k at [k*AW +: AW]
//   flush                           drop queued, unissued entries
//   busy_mask                       bit r set while register r has pending writes
//   sb_err                          sticky: retire seen on a register with count 0
// Configuration macro: SB_BYPASS_EN -- hazard check sees this cycle's retires
// (adds a combinational ret_* -> out_valid path).
module ysyx_25040111_exu_sb
   import ysyx_25040111_exu_sb_pkg::*;
#(
   parameter int AW    = SB_AW,
   parameter int NRET  = SB_NRET,
   parameter int CNTW  = SB_CNTW,
   parameter int DEPTH = SB_DEPTH,
   parameter int PW    = SB_PW
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PW-1:0]      in_payload,
   input  logic [AW-1:0]      in_rd,
   input  logic [AW-1:0]      in_rs1,
   input  logic [AW-1:0]      in_rs2,
   input  logic               in_lock,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PW-1:0]      out_payload,
   output logic [AW-1:0]      out_rd,
   input  logic [NRET-1:0]    ret_valid,
   input  logic [NRET*AW-1:0] ret_rd,
   input  logic               flush,
   output logic [(1<<AW)-1:0] busy_mask,
   output logic               sb_err
);
   localparam int NREG = 1 << AW;
   localparam int EW   = PW + 3*AW + 1;
   localparam int SW   = CNTW + $clog2(NRET+1) + 1;   // room for pend + 1 and NRET hits
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [EW-1:0]   push_data, head_data;
   logic            head_valid, head_lock, hazard, fire;
   logic [AW-1:0]   head_rd, head_rs1, head_rs2;

   logic [CNTW-1:0] pend     [NREG];
   logic [CNTW-1:0] pend_eff [NREG];   // view used by the hazard check
   logic [CNTW-1:0] pend_nxt [NREG];
   logic [SW-1:0]   hits     [NREG];
   logic [SW-1:0]   avail    [NREG];
   logic [NREG-1:0] underflow;

   assign push_data = {in_lock, in_rs2, in_rs1, in_rd, in_payload};
   assign {head_lock, head_rs2, head_rs1, head_rd, out_payload} = head_data;
   assign out_rd = head_rd;

   ysyx_25040111_sfifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_data  (push_data),
      .pop_valid  (head_valid),
      .pop_ready  (fire),
      .pop_data   (head_data)
   );

   // Retire hits per register; register 0 is never tracked.
   // NOTE: every always_comb output gets a default before any condition, so no latches.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         hits[r] = '0;
         if (r != 0) begin
            for (int k = 0; k < NRET; k++) begin
               if (ret_valid[k] && ret_rd[k*AW +: AW] == AW'(r)) hits[r] = hits[r] + SW'(1);
            end
         end
`ifdef SB_BYPASS_EN
         pend_eff[r] = (SW'(pend[r]) < hits[r]) ? '0 : CNTW'(SW'(pend[r]) - hits[r]);
`else
         pend_eff[r] = pend[r];
`endif
      end
   end

   assign hazard    = (pend_eff[head_rs1] != '0) || (pend_eff[head_rs2] != '0) ||
                      (head_lock && head_rd != '0 && pend_eff[head_rd] == CNT_MAX);
   assign out_valid = head_valid & ~hazard & ~flush;
   assign fire      = out_valid & out_ready;

   // Net update: pend + issue increment - retire hits, clamped at zero.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         avail[r]     = SW'(pend[r]) +
                        SW'((r != 0 && fire && head_lock && head_rd == AW'(r)) ? 1 : 0);
         underflow[r] = (avail[r] < hits[r]);
         pend_nxt[r]  = underflow[r] ? '0 : CNTW'(avail[r] - hits[r]);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) pend[r] <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) pend[r] <= pend_nxt[r];
         if (|underflow) sb_err <= 1'b1;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int r = 0; r < NREG; r++) busy_mask[r] = (pend[r] != '0);
   end
endmodule

// File: tb/tb_ysyx_25040111_exu_sb.sv
// Testbench: tb_ysyx_25040111_exu_sb
// Random plus short directed stimulus; a driver pushes each accepted
// instruction into an expected queue and a monitor, running on its own, keeps
// a per-register pending count model, predicts out_valid/in_ready/busy/err
// every cycle and pops/compares the queue head whenever an issue happens.
module tb_ysyx_25040111_exu_sb;
   localparam int AW = 4, NRET = 2, CNTW = 2, DEPTH = 2, PW = 96;
   localparam int NREG = 1 << AW;
   localparam int CMAX = (1 << CNTW) - 1;

   typedef struct {
      logic [PW-1:0] payload;
      logic [AW-1:0] rd, rs1, rs2;
      logic          lock;
   } entry_t;

   logic               clock = 1'b0, reset = 1'b1;
   logic               in_valid = 1'b0, in_lock = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic               in_ready, out_valid, sb_err;
   logic [PW-1:0]      in_payload = '0, out_payload;
   logic [AW-1:0]      in_rd = '0, in_rs1 = '0, in_rs2 = '0, out_rd;
   logic [NRET-1:0]    ret_valid = '0;
   logic [NRET*AW-1:0] ret_rd = '0;
   logic [NREG-1:0]    busy_mask;

   int     n_cmp = 0, n_err = 0;
   entry_t exp_q [$];
   int     pend [NREG] = '{default: 0};
   logic   exp_err = 1'b0;

   always #5 clock = ~clock;

   ysyx_25040111_exu_sb dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_lock(in_lock),
      .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload), .out_rd(out_rd),
      .ret_valid(ret_valid), .ret_rd(ret_rd), .flush(flush),
      .busy_mask(busy_mask), .sb_err(sb_err)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares mid low-phase, then advances the model across the next edge.
   always begin : monitor
      int     hits [NREG];
      int     eff  [NREG];
      entry_t h;
      logic   ev;
      logic [NREG-1:0] exp_busy;
      @(negedge clock);
      #2;
      if (reset) begin
         pend = '{default: 0};
         exp_err = 1'b0;
         exp_q.delete();
      end else begin
         for (int r = 0; r < NREG; r++) hits[r] = 0;
         for (int k = 0; k < NRET; k++)
            if (ret_valid[k] && ret_rd[k*AW +: AW] != 0) hits[ret_rd[k*AW +: AW]]++;
         for (int r = 0; r < NREG; r++) begin
`ifdef SB_BYPASS_EN
            eff[r] = (pend[r] > hits[r]) ? pend[r] - hits[r] : 0;
`else
            eff[r] = pend[r];
`endif
            exp_busy[r] = (pend[r] != 0);
         end
         ev = 1'b0;
         if (exp_q.size() > 0 && !flush) begin
            h  = exp_q[0];
            ev = !(eff[h.rs1] != 0 || eff[h.rs2] != 0 || (h.lock && h.rd != 0 && eff[h.rd] == CMAX));
         end
         check("in_ready", in_ready, exp_q.size() < DEPTH);
         check("out_valid", out_valid, ev);
         check("busy_mask", busy_mask, exp_busy);
         check("sb_err", sb_err, exp_err);
         if (ev && out_ready) begin
            check("out_rd", out_rd, h.rd);
            check("out_payload", out_payload, h.payload);
            void'(exp_q.pop_front());
            if (h.lock && h.rd != 0) pend[h.rd]++;
         end
         for (int r = 0; r < NREG; r++) begin
            pend[r] -= hits[r];
            if (pend[r] < 0) begin
               pend[r] = 0;
               exp_err = 1'b1;
            end
         end
         if (flush) exp_q.delete();
      end
   end

   // One clock of stimulus; the pushed entry is recorded once the edge takes it.
   task automatic step(input logic rst, input logic v, input logic lk,
                       input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic ordy, input logic [NRET-1:0] rv,
                       input logic [NRET*AW-1:0] rrd, input logic fl);
      entry_t e;
      logic   wp;
      @(negedge clock);
      e.payload = {$urandom, $urandom, $urandom};
      e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.lock = lk;
      reset = rst; in_valid = v; in_lock = lk; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_payload = e.payload; out_ready = ordy; ret_valid = rv; ret_rd = rrd; flush = fl;
      #1;
      wp = v && !rst && !fl && (exp_q.size() < DEPTH);
      @(posedge clock);
      if (wp) exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, '0, '0, 1'b0);
   endtask

   initial begin
      repeat (3) step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
      idle(2, 1'b1);

      // Random phase: retires only target registers with outstanding writes.
      for (int c = 0; c < 3000; c++) begin
         logic [NRET-1:0]    rv;
         logic [NRET*AW-1:0] rrd;
         int                 tent [NREG];
         int                 pick;
         tent = pend;
         rv = '0;
         rrd = '0;
         for (int k = 0; k < NRET; k++) begin
            if ($urandom_range(99) < 35) begin
               for (int t = 0; t < 8; t++) begin
                  pick = int'($urandom_range(7, 1));
                  if (!rv[k] && tent[pick] > 0) begin
                     rv[k] = 1'b1;
                     rrd[k*AW +: AW] = AW'(pick);
                     tent[pick]--;
                  end
               end
            end
         end
         step(1'b0, $urandom_range(99) < 70, 1'($urandom_range(1)),
              AW'($urandom_range(7)), AW'($urandom_range(7)), AW'($urandom_range(7)),
              $urandom_range(99) < 70, rv, rrd, $urandom_range(99) < 3);
      end

      // RAW on rd=5: dependent waits for the retire.
      step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 1'b1, '0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 4'd0, 1'b1, '0, '0, 1'b0);
      idle(3, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 2'b01, {4'd0, 4'd5}, 1'b0);
      idle(2, 1'b1);

      // Saturation on rd=7: fourth lock stalls until one retires.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 4'd7, 4'd0, 4'd0, 1'b1, '0, '0, 1'b0);
      idle(3, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 2'b01, {4'd0, 4'd7}, 1'b0);
      idle(2, 1'b1);

      // Flush with pend[3]=1 and two stalled dependents queued.
      step(1'b0, 1'b1, 1'b1, 4'd3, 4'd0, 4'd0, 1'b1, '0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd2, 4'd3, 4'd0, 1'b1, '0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd3, 1'b1, '0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 1'b1, '0, '0, 1'b1);
      idle(2, 1'b1);

      // Double retire of rd=4 on both channels, then underflow.
      step(1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0, 1'b1, '0, '0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0, 1'b1, '0, '0, 1'b0);
      idle(2, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 2'b11, {4'd4, 4'd4}, 1'b0);
      idle(1, 1'b1);
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 2'b01, {4'd0, 4'd4}, 1'b0);
      idle(2, 1'b1);

      // Reset mid-operation, then a stale retire must flag underflow.
      step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 2'b10, {4'd6, 4'd0}, 1'b0);
      idle(3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
